// File: rtl/vm_pkg.sv
// Shared types and defaults for the voting-machine front end.
package vm_pkg;

    localparam int CAND_N             = 4;
    localparam int DEF_DEB_CYCLES     = 4;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_CNT_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DEBOUNCE,
        DRIVE,
        RELEASE
    } state_t;

    function automatic logic is_onehot(input logic [CAND_N-1:0] v);
        return (v != '0) && ((v & (v - CAND_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous candidate buttons.
module btn_sync
    import vm_pkg::*;
#(
    parameter int W = CAND_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ballot_controller.sv
// Ballot sequencer: arms one ballot, qualifies a single debounced press and
// drives a fixed-length one-hot vote pulse into the voting machine.
module ballot_controller
    import vm_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              ballot_issue,
    input  logic              button1,
    input  logic              button2,
    input  logic              button3,
    input  logic              button4,
    output logic [CAND_N-1:0] vote_btn,
    output logic              ballot_ready,
    output logic              busy,
    output logic              vote_done,
    output logic              reject,
    output logic              timeout,
    output logic [CNT_W-1:0]  votes_cast
);

    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [CAND_N-1:0] btn_raw;
    logic [CAND_N-1:0] btn_s;

    state_t            state_q;
    state_t            state_d;
    logic [TMR_W-1:0]  timer_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [CAND_N-1:0] sel_q;
    logic              keep_q;

    logic [CAND_N-1:0] vote_btn_q;
    logic              ballot_ready_q;
    logic              busy_q;
    logic              vote_done_q;
    logic              reject_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  votes_cast_q;

    logic deb_match;
    logic deb_done;
    logic hold_done;
    logic tmr_expired;

    assign btn_raw = {button4, button3, button2, button1};

    btn_sync #(.W(CAND_N)) u_btn_sync (
        .clk    (clk),
        .rst_n  (reset),
        .async_i(btn_raw),
        .sync_o (btn_s)
    );

    assign deb_match   = (btn_s == sel_q);
    assign deb_done    = (deb_cnt_q >= DEB_LAST);
    assign hold_done   = (hold_cnt_q == HOLD_LAST);
    assign tmr_expired = (timer_q >= TMR_LAST);

    // Result mode overrides every state, so a drive in flight is simply abandoned.
    always_comb begin
        state_d = state_q;
        if (mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (ballot_issue) state_d = ARMED;
                ARMED: begin
                    if (tmr_expired)             state_d = IDLE;
                    else if (is_onehot(btn_s))   state_d = DEBOUNCE;
                    else if (btn_s != '0)        state_d = RELEASE;
                end
                DEBOUNCE: begin
                    if (!deb_match)              state_d = ARMED;
                    else if (deb_done)           state_d = DRIVE;
                end
                DRIVE:    if (hold_done) state_d = RELEASE;
                RELEASE:  if (btn_s == '0) state_d = keep_q ? ARMED : IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            deb_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            sel_q          <= '0;
            keep_q         <= 1'b0;
            vote_btn_q     <= '0;
            ballot_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            vote_done_q    <= 1'b0;
            reject_q       <= 1'b0;
            timeout_q      <= 1'b0;
            votes_cast_q   <= '0;
        end else begin
            state_q        <= state_d;
            ballot_ready_q <= (state_d == ARMED) || (state_d == DEBOUNCE);
            busy_q         <= (state_d == DEBOUNCE) || (state_d == DRIVE) || (state_d == RELEASE);
            vote_btn_q     <= (state_d == DRIVE) ? sel_q : '0;
            vote_done_q    <= 1'b0;
            reject_q       <= 1'b0;
            timeout_q      <= 1'b0;

            if (mode) begin
                keep_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ballot_issue) begin
                            timer_q <= '0;
                            keep_q  <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (tmr_expired) begin
                            timeout_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                            if (is_onehot(btn_s)) begin
                                sel_q     <= btn_s;
                                deb_cnt_q <= DEB_W'(1);
                            end else if (btn_s != '0) begin
                                reject_q <= 1'b1;
                                keep_q   <= 1'b1;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        // Saturate so a long debounce cannot wrap the ballot timer.
                        if (!tmr_expired) timer_q <= timer_q + TMR_W'(1);
                        if (deb_match) deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        hold_cnt_q <= '0;
                    end
                    DRIVE: begin
                        if (hold_done) begin
                            hold_cnt_q   <= '0;
                            vote_done_q  <= 1'b1;
                            votes_cast_q <= votes_cast_q + CNT_W'(1);
                            keep_q       <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vote_btn     = vote_btn_q;
    assign ballot_ready = ballot_ready_q;
    assign busy         = busy_q;
    assign vote_done    = vote_done_q;
    assign reject       = reject_q;
    assign timeout      = timeout_q;
    assign votes_cast   = votes_cast_q;

endmodule

// File: doc/ballot_controller.md
Name: ballot_controller

Overview:
Front-end sequencer for the 4-candidate voting machine.
- Issues one ballot per voter and qualifies a single candidate press.
- Drives the machine's button1..button4 inputs with a clean one-hot pulse held long enough for the machine to count exactly one vote.
- Rejects multi-button presses, times out abandoned ballots, and blocks voting while mode=1 (result display).

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized cycles needed to accept a single press
HOLD_CYCLES, 16, cycles the one-hot vote is driven on vote_btn
TIMEOUT_CYCLES, 1000, ARMED cycles before an unused ballot is cancelled
CNT_W, 8, width of votes_cast

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
mode  in  1  0 = voting, 1 = result mode (voting blocked)
ballot_issue  in  1  officer ballot grant; sampled each cycle
button1  in  1  candidate 1 press (asynchronous)
button2  in  1  candidate 2 press
button3  in  1  candidate 3 press
button4  in  1  candidate 4 press
vote_btn  out  4  one-hot drive to the voting machine; bit0 = button1
ballot_ready  out  1  ballot armed, awaiting press (ARMED/DEBOUNCE)
busy  out  1  high in DEBOUNCE, DRIVE and RELEASE
vote_done  out  1  1-cycle pulse when a vote drive completes
reject  out  1  1-cycle pulse on a multi-button press
timeout  out  1  1-cycle pulse when a ballot expires
votes_cast  out  CNT_W  completed votes, wraps modulo 2^CNT_W

Behaviour:
Reset and outputs
- reset=0: state IDLE; all outputs, timers, sync flops and votes_cast cleared immediately.
- All outputs are registered.

Synchronizer
- Buttons pass through 2-flop synchronizers to form btn_s[3:0].
- Latency is 2 cycles.

IDLE
- ballot_issue=1 and mode=0 moves to ARMED next cycle and clears the timer.
- Buttons are ignored in IDLE.

ARMED
- Timer increments each cycle.
- btn_s == 0: stay in ARMED.
- Exactly one bit of btn_s set: latch it as sel, deb_cnt=1, go to DEBOUNCE.
- More than one bit set: pulse reject, set keep=1, go to RELEASE.
- Timer reaches TIMEOUT_CYCLES-1 with no accepted press: pulse timeout, go to IDLE.
- The timer is not cleared by a failed debounce.

DEBOUNCE
- The timer keeps running.
- btn_s == sel: deb_cnt increments. When deb_cnt reaches DEB_CYCLES, go to DRIVE.
- btn_s != sel (release, or an extra button): return to ARMED with no pulse.

DRIVE
- vote_btn = sel for exactly HOLD_CYCLES cycles.
- Buttons are ignored.
- After the last drive cycle, vote_btn=0, vote_done pulses, votes_cast increments, keep=0, and the state goes to RELEASE.

RELEASE
- Wait for the first cycle with btn_s == 0.
- Then go to ARMED if keep=1 (timer value preserved), otherwise to IDLE.

Boundary conditions
- mode=1 in any state: next state is IDLE and vote_btn=0 next cycle. A truncated DRIVE gives no vote_done and no count. votes_cast is preserved.
- ballot_issue outside IDLE is ignored; ballots do not queue.
- ballot_issue and mode=1 in the same cycle: mode wins.
- votes_cast at max value: wraps to 0 on the next vote.

Decomposition:
- Package vm_pkg:
  - CAND_N=4
  - state enum {IDLE, ARMED, DEBOUNCE, DRIVE, RELEASE}
  - is_onehot function
  - default parameter constants
- Sub-module btn_sync: 2-flop synchronizer with async active-low clear, instantiated per button or as a 4-bit vector.
- The FSM, timer, debounce counter and hold counter stay in ballot_controller.

Test Plan:
1. Release reset; pulse ballot_issue; hold button2 for 30 cycles -> vote_btn=4'b0010 from cycle 2+4 after the press for 16 cycles; then vote_done pulses once and votes_cast=1; after release, ballot_ready=0.
2. Armed ballot; press button2 and button3 together -> reject pulses once and vote_btn stays 0; after release ballot_ready=1; then hold button1 -> vote_btn=4'b0001 and votes_cast increments by 1.
3. No ballot issued; hold button4 for 50 cycles -> vote_btn=0, busy=0, votes_cast unchanged.
4. Armed ballot; 2-cycle button3 glitch -> no DRIVE and no reject; ballot_ready stays 1.
5. TIMEOUT_CYCLES=50; issue a ballot with no press -> timeout pulses on cycle 50 and ballot_ready=0; a later press is ignored.
6. mode=1 asserted at cycle 5 of DRIVE -> vote_btn=0 next cycle, no vote_done, state IDLE. Separately, reset=0 mid-DRIVE -> all outputs 0 immediately.
